// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of {pc, inst} pairs between the fetch and decode stages.
//
// Parameters
//   XLEN  : width of the PC and instruction fields
//   DEPTH : number of entries (power of two, >= 2)
//
// Ports
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   in_valid  in   fetch presents {in_pc, in_inst}
//   in_pc     in   PC of the fetched instruction
//   in_inst   in   fetched instruction code
//   in_ready  out  a push is accepted this cycle (drives fetch pc_write)
//   flush     in   discard all entries (redirect)
//   out_valid out  head entry is valid for decode
//   out_pc    out  PC of the head entry (0 when empty)
//   out_inst  out  instruction of the head entry (0 when empty)
//   out_ready in   decode consumes the head this cycle
//   count     out  number of stored entries
//
// Build option
//   FETCH_QUEUE_BYPASS_EN : when the queue is empty, forward in_* straight to
//   out_* in the same cycle. If decode takes it, the entry is never written.
module fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_inst,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_inst,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] r_pc   [DEPTH];
  logic [XLEN-1:0] r_inst [DEPTH];
  logic [PW-1:0]   r_rd, r_wr;
  logic [CW-1:0]   r_count;

  logic w_full, w_empty, w_byp, w_push, w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // reset term holds in_ready low while reset is asserted, independent of clock
  assign in_ready = !w_full && !flush && !reset;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_byp = w_empty && in_valid && !flush && !reset;
`else
  assign w_byp = 1'b0;
`endif

  // a bypassed entry consumed in the same cycle never lands in storage
  assign w_push = in_valid && in_ready && !(w_byp && out_ready);
  assign w_pop  = !w_empty && out_ready && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign out_valid = !w_empty || w_byp;
  assign out_pc    = w_byp ? in_pc   : (w_empty ? '0 : r_pc[r_rd]);
  assign out_inst  = w_byp ? in_inst : (w_empty ? '0 : r_inst[r_rd]);
`else
  assign out_valid = !w_empty;
  assign out_pc    = w_empty ? '0 : r_pc[r_rd];
  assign out_inst  = w_empty ? '0 : r_inst[r_rd];
`endif

  assign count = r_count;

  // DEPTH is a power of two, so pointer increments wrap naturally
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // storage is not reset and survives flush; only pointers/count are cleared
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_pc[r_wr]   <= in_pc;
      r_inst[r_wr] <= in_inst;
    end
  end

endmodule
